sipo_buffer: RTL

SIPO_BUFFER -- requirements
Module: sipo_buffer

---
 rtl/coproc_pkg.sv | 9 +
 rtl/sipo_buffer.sv | 102 ++++++++++
 2 files changed

// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: state encodings used by the streaming blocks.
package coproc_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DONE = 1'b1
  } sipo_state_e;

endpackage : coproc_pkg

// File: rtl/sipo_buffer.sv
// Serial-in / parallel-out vector buffer: assembles up to DEPTH beats into q,
// then holds the vector until the consumer takes it.
module sipo_buffer
  import coproc_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [DEPTH-1:0][WIDTH-1:0]  q,
  output logic [$clog2(DEPTH):0]       out_len,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  sipo_state_e                 r_state;
  sipo_state_e                 w_next_state;
  logic [AW-1:0]               r_addr;
  logic [DEPTH-1:0][WIDTH-1:0] r_q;
  logic [DEPTH-1:0][WIDTH-1:0] w_q_next;
  logic [LW-1:0]               r_out_len;
  logic                        w_accept;
  logic                        w_final_beat;
  logic                        w_release;

  assign w_accept     = in_valid && in_ready;
  assign w_final_beat = w_accept && (in_last || (r_addr == LAST_ADDR));
  assign w_release    = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FILL: if (w_final_beat) w_next_state = ST_DONE;
      ST_DONE: if (w_release)    w_next_state = ST_FILL;
      default: w_next_state = ST_FILL;
    endcase
  end

  // Handshake outputs decode from the state; reset masks in_ready immediately
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_FILL: in_ready  = !rst;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // First beat of a vector wipes stale entries left by a longer previous vector
  always_comb begin
    w_q_next = r_q;
    if (w_accept) begin
      if (r_addr == '0) begin
        w_q_next = '0;
      end
      w_q_next[r_addr] = in_data;
    end
  end

  // Datapath: address counter, vector storage, length capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_q       <= '0;
      r_out_len <= '0;
    end else begin
      r_q <= w_q_next;
      if (w_final_beat) begin
        r_out_len <= LW'(r_addr) + LW'(1);
      end else if (w_accept) begin
        r_addr <= r_addr + AW'(1);
      end
      if (w_release) begin
        r_addr <= '0;
      end
    end
  end

  assign q       = r_q;
  assign out_len = r_out_len;

endmodule : sipo_buffer
